pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DW, default 7, duty-value width in bits.
REQ-002 SHALL have parameter DMAX, default 100, maximum legal duty value (percent).
REQ-003 SHALL have parameter STEP, default 1, ramp increment per applied period tick.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  block enable; low freezes all state.
REQ-007 SHALL have port period_tick  input  1  one-cycle pulse from the PWM generator at each period start.
REQ-008 SHALL have port wr_valid  input  1  write request.
REQ-009 SHALL have port wr_ready  output  1  write acceptance; a write transfers when wr_valid and wr_ready are both high.
REQ-010 SHALL have port wr_ch  input  2  target channel (0..2 legal, 3 illegal).
REQ-011 SHALL have port wr_duty  input  DW  requested duty.
REQ-012 SHALL have ports duty0, duty1, duty2  output  DW each  current duty fed to PWM channels 0..2.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an illegal-channel write.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED and APPLY; duty outputs change only in the APPLY cycle.
REQ-016 SHALL drive wr_ready high in IDLE and ARMED when ena=1, and low in APPLY or when ena=0.
REQ-017 SHALL, on a transfer with wr_ch<=2, store min(wr_duty, DMAX) into target[wr_ch]; later writes to the same channel before APPLY overwrite earlier ones.
REQ-018 SHALL, on a transfer with wr_ch=3, discard the data, pulse err the next cycle, and leave state unchanged.
REQ-019 SHALL move IDLE->ARMED on the cycle after any legal transfer.
REQ-020 SHALL move ARMED->APPLY on period_tick; period_tick in IDLE is ignored.
REQ-021 SHALL, when a legal write and period_tick coincide in ARMED, capture the write and make it visible in the following APPLY cycle.
REQ-022 SHALL, in APPLY, update each channel i: if |target-duty| >= STEP, step duty by STEP toward target; otherwise set duty=target.
REQ-023 SHALL, after APPLY, go to IDLE if all duty equal target, otherwise to ARMED.
REQ-024 SHALL keep all arithmetic DW+1 bits wide internally, so no duty ever wraps below 0 or above DMAX.
REQ-025 SHALL hold state, targets, duties and err low while ena=0; wr_valid and period_tick are ignored.

Reset
REQ-026 SHALL, on rst_n low, immediately clear duty0..2 and target0..2 to 0, set state to IDLE, and drive err=0, busy=0 and wr_ready=0.
REQ-027 SHALL, on a reset asserted mid-ramp, abandon the ramp with no residual pending update after release.

Configuration
REQ-028 SHALL use macro PWM_RAMP_EN: when defined, APPLY ramps per REQ-022; when undefined, APPLY loads duty=target directly and always returns to IDLE.

Verification
REQ-029 SHALL cover: ch0 written 5, STEP=1, PWM_RAMP_EN defined -> duty0 = 1,2,3,4,5 on five successive ticks, then busy=0.
REQ-030 SHALL cover: ch1 written 120 -> target1 clamps to 100, and duty1 never exceeds 100.
REQ-031 SHALL cover: wr_ch=3 with wr_duty=50 -> err pulses one cycle, all duties unchanged, state unchanged.
REQ-032 SHALL cover: write ch2=7 in the same cycle as period_tick while ARMED -> the APPLY cycle moves duty2 toward 7.
REQ-033 SHALL cover: rst_n pulsed low while duty0 ramps 0->40 at value 12 -> all outputs are 0 immediately, and state is IDLE after release.
REQ-034 SHALL cover: PWM_RAMP_EN undefined, ch0 written 60 -> duty0=60 after the first tick, and busy=0 on the next cycle.

Source files
------------

// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - duty write handshake between a register master and pwm_ramp_ctrl
interface pwm_ramp_ctrl_if #(
    parameter int DW = 7
);
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    wr_ch;
    logic [DW-1:0] wr_duty;

    modport master (output wr_valid, output wr_ch, output wr_duty, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - three-channel PWM duty ramp controller; define PWM_RAMP_EN for stepped ramping, else direct load
module pwm_ramp_ctrl #(
    parameter int DW   = 7,
    parameter int DMAX = 100,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           period_tick,
    pwm_ramp_ctrl_if.slave wr,
    output logic [DW-1:0]  duty0,
    output logic [DW-1:0]  duty1,
    output logic [DW-1:0]  duty2,
    output logic           busy,
    output logic           err
);

    localparam int unsigned FULL_RANGE = 1 << (DW + 1);
`ifdef PWM_RAMP_EN
    localparam int unsigned STEP_EFF = STEP;
`else
    // Without ramping every step spans the whole duty range, so APPLY lands on target at once.
    localparam int unsigned STEP_EFF = (STEP > FULL_RANGE) ? STEP : FULL_RANGE;
`endif
    localparam logic [DW:0] W_STEP = (DW + 1)'(STEP_EFF);
    localparam logic [DW:0] W_DMAX = (DW + 1)'(DMAX);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

    state_t        r_state;
    logic [DW-1:0] r_target [3];
    logic [DW-1:0] r_duty   [3];
    logic          r_err;

    logic          w_xfer;
    logic          w_legal;
    logic [DW-1:0] w_wr_clamped;
    logic [DW-1:0] w_duty_nxt [3];
    logic          w_settled;

    // Move one channel toward its target; all math is DW+1 wide so nothing wraps.
    function automatic logic [DW-1:0] f_step(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
        logic [DW:0] c;
        logic [DW:0] t;
        logic [DW:0] d;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t >= c) begin
            d = t - c;
            if (32'(d) >= STEP_EFF) return DW'(c + W_STEP);
            return tgt;
        end
        d = c - t;
        if (32'(d) >= STEP_EFF) return DW'(c - W_STEP);
        return tgt;
    endfunction

    assign wr.wr_ready   = rst_n & ena & (r_state != APPLY);
    assign w_xfer        = wr.wr_valid & wr.wr_ready;
    assign w_legal       = w_xfer & (wr.wr_ch != 2'd3);
    assign w_wr_clamped  = ({1'b0, wr.wr_duty} > W_DMAX) ? W_DMAX[DW-1:0] : wr.wr_duty;

    // Next duty per channel and whether the APPLY result reaches every target.
    always_comb begin
        w_settled = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_duty_nxt[i] = f_step(r_duty[i], r_target[i]);
            if (w_duty_nxt[i] != r_target[i]) w_settled = 1'b0;
        end
    end

    // Control FSM: capture writes, wait for a period tick, apply one ramp step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_target[i] <= '0;
                r_duty[i]   <= '0;
            end
        end else if (ena) begin
            r_err <= w_xfer & (wr.wr_ch == 2'd3);
            for (int i = 0; i < 3; i++) begin
                if (w_legal && (wr.wr_ch == 2'(i))) r_target[i] <= w_wr_clamped;
            end
            case (r_state)
                IDLE: begin
                    if (w_legal) r_state <= ARMED;
                end
                ARMED: begin
                    if (period_tick) r_state <= APPLY;
                end
                APPLY: begin
                    for (int i = 0; i < 3; i++) r_duty[i] <= w_duty_nxt[i];
                    r_state <= w_settled ? IDLE : ARMED;
                end
                default: r_state <= IDLE;
            endcase
        end else begin
            r_err <= 1'b0;
        end
    end

    assign duty0 = r_duty[0];
    assign duty1 = r_duty[1];
    assign duty2 = r_duty[2];
    assign busy  = (r_state != IDLE);
    assign err   = r_err;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;
    localparam int DW = 7;
`ifdef PWM_RAMP_EN
    localparam logic [DW-1:0] D0 = 7'd5;
`else
    localparam logic [DW-1:0] D0 = 7'd60;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          period_tick;
    logic [DW-1:0] duty0;
    logic [DW-1:0] duty1;
    logic [DW-1:0] duty2;
    logic          busy;
    logic          err;
    int            total = 0;
    int            bad   = 0;
    int            peak  = 0;

    pwm_ramp_ctrl_if #(.DW(DW)) wr_if ();

    pwm_ramp_ctrl #(.DW(DW), .DMAX(100), .STEP(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .period_tick (period_tick),
        .wr          (wr_if),
        .duty0       (duty0),
        .duty1       (duty1),
        .duty2       (duty2),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [DW-1:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = ch;
        wr_if.wr_duty  = d;
        cyc();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic apply_tick();
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; period_tick = 1'b0;
        wr_if.wr_valid = 1'b0; wr_if.wr_ch = 2'd0; wr_if.wr_duty = '0;
        cyc(); cyc();
        chk("rst_duty0", duty0, 0);
        chk("rst_duty1", duty1, 0);
        chk("rst_duty2", duty2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        ena = 1'b1; #1;
        chk("rst_ready_ena", wr_if.wr_ready, 0);
        rst_n = 1'b1; #1;
        chk("idle_ready", wr_if.wr_ready, 1);
        cyc();

        // first write, tick, apply
        wr(2'd0, D0);
        chk("armed_busy", busy, 1);
        chk("armed_duty0", duty0, 0);
        period_tick = 1'b1; cyc(); period_tick = 1'b0;
        chk("apply_busy", busy, 1);
        chk("apply_ready", wr_if.wr_ready, 0);
        chk("apply_duty0_hold", duty0, 0);
        cyc();
`ifdef PWM_RAMP_EN
        chk("ramp_d0_1", duty0, 1);
        chk("ramp_busy_1", busy, 1);
        for (int k = 2; k <= 5; k++) begin
            apply_tick();
            chk($sformatf("ramp_d0_%0d", k), duty0, k);
        end
        chk("ramp_done_busy", busy, 0);
`else
        chk("direct_duty0", duty0, 60);
        chk("direct_busy", busy, 0);
`endif

        // clamp above DMAX
        wr(2'd1, 7'd120);
`ifdef PWM_RAMP_EN
        for (int k = 0; k < 100; k++) begin
            apply_tick();
            if (int'(duty1) > peak) peak = int'(duty1);
        end
        chk("clamp_peak", peak, 100);
`else
        apply_tick();
`endif
        chk("clamp_duty1", duty1, 100);
        chk("clamp_busy", busy, 0);

        // illegal channel
        wr(2'd3, 7'd50);
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_duty0", duty0, D0);
        chk("ill_duty1", duty1, 100);
        chk("ill_duty2", duty2, 0);
        cyc();
        chk("ill_err_clear", err, 0);
        period_tick = 1'b1; cyc(); period_tick = 1'b0;
        chk("idle_tick_busy", busy, 0);
        cyc();
        chk("idle_tick_duty0", duty0, D0);

        // write coinciding with tick in ARMED
        wr(2'd0, D0);
        chk("coin_armed", busy, 1);
        wr_if.wr_valid = 1'b1; wr_if.wr_ch = 2'd2; wr_if.wr_duty = 7'd7; period_tick = 1'b1;
        cyc();
        wr_if.wr_valid = 1'b0; period_tick = 1'b0;
        chk("coin_apply_ready", wr_if.wr_ready, 0);
        cyc();
`ifdef PWM_RAMP_EN
        chk("coin_duty2_1", duty2, 1);
        chk("coin_busy_mid", busy, 1);
        for (int k = 0; k < 6; k++) apply_tick();
`endif
        chk("coin_duty2", duty2, 7);
        chk("coin_busy", busy, 0);

        // enable low freezes everything
        wr(2'd1, 7'd30);
        chk("ena_armed", busy, 1);
        ena = 1'b0; #1;
        chk("ena_ready", wr_if.wr_ready, 0);
        wr_if.wr_valid = 1'b1; wr_if.wr_ch = 2'd0; wr_if.wr_duty = 7'd9; period_tick = 1'b1;
        cyc(); cyc();
        chk("ena_busy_held", busy, 1);
        chk("ena_duty1_held", duty1, 100);
        chk("ena_err", err, 0);
        wr_if.wr_valid = 1'b0; period_tick = 1'b0; ena = 1'b1;
        apply_tick();
        chk("ena_duty0_ignored", duty0, D0);
`ifdef PWM_RAMP_EN
        chk("ena_duty1_step", duty1, 99);
`else
        chk("ena_duty1_load", duty1, 30);
`endif

        // reset in the middle of an update
`ifdef PWM_RAMP_EN
        rst_n = 1'b0; cyc(); rst_n = 1'b1; #1;
        wr(2'd0, 7'd40);
        for (int k = 0; k < 12; k++) apply_tick();
        chk("mid_duty0", duty0, 12);
`else
        wr(2'd0, 7'd40);
        period_tick = 1'b1; cyc(); period_tick = 1'b0;
`endif
        chk("mid_busy", busy, 1);
        #2; rst_n = 1'b0; #1;
        chk("mrst_duty0", duty0, 0);
        chk("mrst_duty1", duty1, 0);
        chk("mrst_duty2", duty2, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err, 0);
        chk("mrst_ready", wr_if.wr_ready, 0);
        cyc();
        rst_n = 1'b1; #1;
        chk("post_rst_ready", wr_if.wr_ready, 1);
        chk("post_rst_busy", busy, 0);
        apply_tick();
        chk("post_rst_duty0", duty0, 0);
        chk("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
